// File: rtl/if_id_skid_if.sv
// Fetch-to-decode bus for the IF/ID skid register.
// The fetch side drives the returning instruction; the decode side receives
// the registered copy.
interface if_id_skid_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_valid;

  modport master (
    output if_pc, if_inst, if_valid,
    input  id_pc, id_inst, id_valid
  );

  modport slave (
    input  if_pc, if_inst, if_valid,
    output id_pc, id_inst, id_valid
  );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with an in-order skid FIFO.
// Instructions returning from synchronous memory while decode is held are
// parked in a small circular buffer and replayed in program order once the
// hold releases. A flush empties everything; a sticky flag records drops.
module if_id_skid #(
  parameter int              ADDR_W       = 32,
  parameter int              INST_W       = 32,
  parameter int              DEPTH        = 2,
  parameter int              STALL_W      = 6,
  parameter int              ID_STALL_IDX = 2,
  parameter logic [ADDR_W-1:0] INIT_PC    = ADDR_W'(32'h0000_0000),
  parameter logic [INST_W-1:0] NOP_INST   = INST_W'(32'h0000_0000)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [STALL_W-1:0]           stall,
  input  logic                         flush,
  if_id_skid_if.slave                  bus,
  output logic [$clog2(DEPTH+1)-1:0]   buf_count,
  output logic                         buf_overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Pointer advance that wraps at DEPTH rather than at the power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      next_ptr = {PTR_W{1'b0}};
    end else begin
      next_ptr = p + PTR_W'(1);
    end
  endfunction

  logic [ADDR_W-1:0] mem_pc_r   [DEPTH];
  logic [INST_W-1:0] mem_inst_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              overflow_r;
  logic [ADDR_W-1:0] id_pc_r;
  logic [INST_W-1:0] id_inst_r;
  logic              id_valid_r;

  logic hold_s;
  logic empty_s;
  logic full_s;
  logic push_s;
  logic pop_s;
  logic load_in_s;
  logic set_ovf_s;
  logic unused_stall_s;

  assign hold_s         = stall[ID_STALL_IDX];
  assign unused_stall_s = ^stall;
  assign empty_s        = (count_r == {CNT_W{1'b0}});
  assign full_s         = (count_r == CNT_W'(DEPTH));

  // Decide this cycle's FIFO traffic and decode load; flush beats hold beats advance.
  always_comb begin
    push_s    = 1'b0;
    pop_s     = 1'b0;
    load_in_s = 1'b0;
    set_ovf_s = 1'b0;
    if (flush) begin
      // Incoming fetch data is discarded along with the buffer contents.
      push_s = 1'b0;
    end else if (hold_s) begin
      if (bus.if_valid) begin
        if (!full_s) begin
          push_s = 1'b1;
        end else begin
          set_ovf_s = 1'b1;
        end
      end else begin
        push_s = 1'b0;
      end
    end else begin
      if (!empty_s) begin
        // Buffered work goes first; a new arrival queues behind it.
        pop_s  = 1'b1;
        push_s = bus.if_valid;
      end else begin
        load_in_s = bus.if_valid;
      end
    end
  end

  // Skid storage: write the incoming entry at the tail on a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_r[i]   <= INIT_PC;
        mem_inst_r[i] <= NOP_INST;
      end
    end else if (push_s) begin
      mem_pc_r[wr_ptr_r]   <= bus.if_pc;
      mem_inst_r[wr_ptr_r] <= bus.if_inst;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky drop flag, cleared only by flush or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (flush) begin
      overflow_r <= 1'b0;
    end else if (set_ovf_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Decode-side register: freeze on hold, else take head, bypass, or bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_r    <= INIT_PC;
      id_inst_r  <= NOP_INST;
      id_valid_r <= 1'b0;
    end else if (flush) begin
      id_pc_r    <= INIT_PC;
      id_inst_r  <= NOP_INST;
      id_valid_r <= 1'b0;
    end else if (hold_s) begin
      id_pc_r    <= id_pc_r;
      id_inst_r  <= id_inst_r;
      id_valid_r <= id_valid_r;
    end else if (pop_s) begin
      id_pc_r    <= mem_pc_r[rd_ptr_r];
      id_inst_r  <= mem_inst_r[rd_ptr_r];
      id_valid_r <= 1'b1;
    end else if (load_in_s) begin
      id_pc_r    <= bus.if_pc;
      id_inst_r  <= bus.if_inst;
      id_valid_r <= 1'b1;
    end else begin
      id_pc_r    <= INIT_PC;
      id_inst_r  <= NOP_INST;
      id_valid_r <= 1'b0;
    end
  end

  assign bus.id_pc    = id_pc_r;
  assign bus.id_inst  = id_inst_r;
  assign bus.id_valid = id_valid_r;
  assign buf_count    = count_r;
  assign buf_overflow = overflow_r;

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench for if_id_skid: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_if_id_skid;
  localparam int              ADDR_W  = 32;
  localparam int              INST_W  = 32;
  localparam int              DEPTH   = 2;
  localparam int              STALL_W = 6;
  localparam int              IDX     = 2;
  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam logic [31:0]     INIT_PC = 32'hBFC0_0000;
  localparam logic [31:0]     NOP     = 32'h0000_0013;
  localparam logic [STALL_W-1:0] HOLD  = 6'b000100;
  localparam logic [STALL_W-1:0] NOISE = 6'b111011;
  localparam logic [STALL_W-1:0] RUN   = 6'b000000;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [CNT_W-1:0]   buf_count;
  logic               buf_overflow;

  if_id_skid_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

  if_id_skid #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .STALL_W(STALL_W),
    .ID_STALL_IDX(IDX), .INIT_PC(INIT_PC), .NOP_INST(NOP)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus),
    .buf_count(buf_count), .buf_overflow(buf_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of {pc, inst} plus the expected decode view.
  logic [63:0] mq [$];
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic        exp_valid;
  logic        exp_ovf;
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_pc = INIT_PC; exp_inst = NOP; exp_valid = 1'b0; exp_ovf = 1'b0;
  endtask

  // What the decode view and buffer must be after the coming edge.
  task automatic model_step(input logic hold, input logic fl, input logic v,
                            input logic [31:0] pc, input logic [31:0] inst);
    logic [63:0] head;
    if (fl) begin
      model_reset();
    end else if (hold) begin
      if (v) begin
        if (mq.size() < DEPTH) mq.push_back({pc, inst});
        else exp_ovf = 1'b1;
      end
    end else if (mq.size() > 0) begin
      head = mq.pop_front();
      exp_pc = head[63:32]; exp_inst = head[31:0]; exp_valid = 1'b1;
      if (v) mq.push_back({pc, inst});
    end else if (v) begin
      exp_pc = pc; exp_inst = inst; exp_valid = 1'b1;
    end else begin
      exp_pc = INIT_PC; exp_inst = NOP; exp_valid = 1'b0;
    end
  endtask

  // Every cycle: compare DUT outputs against the model, just after the edge.
  always @(posedge clk) begin
    #1;
    check("id_valid", 64'(bus.id_valid), 64'(exp_valid));
    check("id_pc", 64'(bus.id_pc), 64'(exp_pc));
    check("id_inst", 64'(bus.id_inst), 64'(exp_inst));
    check("buf_count", 64'(buf_count), 64'(mq.size()));
    check("buf_overflow", 64'(buf_overflow), 64'(exp_ovf));
  end

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    mk_inst = (pc * 32'd3) ^ 32'h1357_0000;
  endfunction

  task automatic step_now(input logic [STALL_W-1:0] st, input logic fl, input logic v,
                          input logic [31:0] pc, input logic [31:0] inst);
    stall = st; flush = fl; bus.if_valid = v; bus.if_pc = pc; bus.if_inst = inst;
    model_step(st[IDX], fl, v, pc, inst);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [STALL_W-1:0] st, input logic fl, input logic v,
                     input logic [31:0] pc);
    @(negedge clk);
    step_now(st, fl, v, pc, mk_inst(pc));
  endtask

  // Assert reset between edges, check outputs at once, release on the next low phase.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check({tag, "_valid"}, 64'(bus.id_valid), 64'd0);
    check({tag, "_pc"}, 64'(bus.id_pc), 64'(INIT_PC));
    check({tag, "_inst"}, 64'(bus.id_inst), 64'(NOP));
    check({tag, "_count"}, 64'(buf_count), 64'd0);
    check({tag, "_ovf"}, 64'(buf_overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step_now(RUN, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = RUN; flush = 1'b0;
    bus.if_valid = 1'b0; bus.if_pc = 32'h0; bus.if_inst = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.id_valid), 64'd0);
    check("rst_pc", 64'(bus.id_pc), 64'(INIT_PC));
    check("rst_inst", 64'(bus.id_inst), 64'(NOP));
    check("rst_count", 64'(buf_count), 64'd0);
    check("rst_ovf", 64'(buf_overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step_now(RUN, 1'b0, 1'b0, 32'h0, 32'h0);

    // Straight-through flow, with unrelated stall bits toggled.
    cyc(NOISE, 1'b0, 1'b1, 32'h4);
    check("t1_pc4", 64'(bus.id_pc), 64'h4);
    check("t1_inst4", 64'(bus.id_inst), 64'(mk_inst(32'h4)));
    check("t1_valid", 64'(bus.id_valid), 64'd1);
    cyc(NOISE, 1'b0, 1'b1, 32'h8);
    check("t1_pc8", 64'(bus.id_pc), 64'h8);
    cyc(RUN, 1'b0, 1'b1, 32'hC);
    check("t1_pcC", 64'(bus.id_pc), 64'hC);
    check("t1_count", 64'(buf_count), 64'd0);

    // Hold two arrivals, then drain them in order and bubble.
    cyc(HOLD, 1'b0, 1'b1, 32'h10);
    check("t2_frozen", 64'(bus.id_pc), 64'hC);
    check("t2_cnt1", 64'(buf_count), 64'd1);
    cyc(HOLD, 1'b0, 1'b1, 32'h14);
    check("t2_frozen2", 64'(bus.id_pc), 64'hC);
    check("t2_cnt2", 64'(buf_count), 64'd2);
    cyc(RUN, 1'b0, 1'b0, 32'h0);
    check("t2_pc10", 64'(bus.id_pc), 64'h10);
    cyc(RUN, 1'b0, 1'b0, 32'h0);
    check("t2_pc14", 64'(bus.id_pc), 64'h14);
    check("t2_cnt0", 64'(buf_count), 64'd0);
    cyc(RUN, 1'b0, 1'b0, 32'h0);
    check("t2_bub_valid", 64'(bus.id_valid), 64'd0);
    check("t2_bub_inst", 64'(bus.id_inst), 64'(NOP));

    // Overflow while held, then pop-and-push with a full buffer.
    cyc(HOLD, 1'b0, 1'b1, 32'h20);
    cyc(HOLD, 1'b0, 1'b1, 32'h24);
    cyc(HOLD, 1'b0, 1'b1, 32'h28);
    check("t3_cnt", 64'(buf_count), 64'd2);
    check("t3_ovf", 64'(buf_overflow), 64'd1);
    cyc(RUN, 1'b0, 1'b1, 32'h30);
    check("t4_pc20", 64'(bus.id_pc), 64'h20);
    check("t4_cnt2", 64'(buf_count), 64'd2);
    cyc(RUN, 1'b0, 1'b0, 32'h0);
    check("t4_pc24", 64'(bus.id_pc), 64'h24);
    cyc(RUN, 1'b0, 1'b0, 32'h0);
    check("t4_pc30", 64'(bus.id_pc), 64'h30);
    check("t4_ovf_sticky", 64'(buf_overflow), 64'd1);
    cyc(RUN, 1'b0, 1'b0, 32'h0);
    check("t4_no28", 64'(bus.id_valid), 64'd0);

    // Flush beats hold and a valid arrival.
    cyc(RUN, 1'b0, 1'b1, 32'h3C);
    cyc(HOLD, 1'b0, 1'b1, 32'h40);
    cyc(HOLD, 1'b0, 1'b1, 32'h44);
    check("t5_cnt2", 64'(buf_count), 64'd2);
    cyc(HOLD, 1'b1, 1'b1, 32'h48);
    check("t5_valid", 64'(bus.id_valid), 64'd0);
    check("t5_pc", 64'(bus.id_pc), 64'(INIT_PC));
    check("t5_cnt0", 64'(buf_count), 64'd0);
    check("t5_ovf0", 64'(buf_overflow), 64'd0);
    cyc(RUN, 1'b0, 1'b0, 32'h0);
    check("t5_no48", 64'(bus.id_valid), 64'd0);

    // Asynchronous reset mid-hold drops the buffered entry.
    cyc(RUN, 1'b0, 1'b1, 32'h4C);
    cyc(HOLD, 1'b0, 1'b1, 32'h50);
    check("t6_cnt1", 64'(buf_count), 64'd1);
    async_reset("t6_arst");
    check("t6_no50", 64'(bus.id_valid), 64'd0);

    // Randomized traffic, alternating light and heavy hold phases.
    for (int i = 0; i < 3000; i++) begin
      logic [STALL_W-1:0] st;
      int hold_pct;
      hold_pct = ((i / 200) % 2 == 1) ? 70 : 20;
      st = STALL_W'($urandom);
      st[IDX] = ($urandom_range(0, 99) < hold_pct);
      @(negedge clk);
      step_now(st, ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 75),
               $urandom, $urandom);
      if ($urandom_range(0, 299) == 0) async_reset("rnd_arst");
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
- Parametrised IF/ID pipeline register for a fetch path with synchronous instruction memory. An instruction returns one cycle after its PC.
- Adds a small in-order skid FIFO, so instructions returned while decode is stalled are kept, not lost, and replayed once the stall releases.
- Adds a per-entry valid bit, a branch flush, and overflow detection.
- Sits between the fetch stage (pc_reg plus inst memory) and the decode stage.

Parameters:
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- DEPTH, 2, skid FIFO entries (1..8)
- STALL_W, 6, width of the pipeline stall vector
- ID_STALL_IDX, 2, stall vector bit that freezes decode
- INIT_PC, 32'h0000_0000, PC value driven when there is no valid instruction
- NOP_INST, 32'h0000_0000, instruction value driven on a bubble

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  STALL_W  pipeline stall vector; only bit ID_STALL_IDX is used
- flush  in  1  branch/exception flush; kills decode and empties the FIFO
- if_pc  in  ADDR_W  PC of the returning instruction
- if_inst  in  INST_W  instruction returned by memory
- if_valid  in  1  qualifies if_pc and if_inst this cycle
- id_pc  out  ADDR_W  registered PC presented to decode
- id_inst  out  INST_W  registered instruction presented to decode
- id_valid  out  1  id_pc and id_inst hold a real instruction
- buf_count  out  $clog2(DEPTH+1)  current FIFO occupancy
- buf_overflow  out  1  sticky: an instruction was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, any time, including mid-stall):
  - id_pc=INIT_PC, id_inst=NOP_INST, id_valid=0
  - FIFO empty, buf_count=0, buf_overflow=0
- Define hold = stall[ID_STALL_IDX]. Per-cycle priority is flush > hold > advance.
- Flush:
  - id_pc=INIT_PC, id_inst=NOP_INST, id_valid=0
  - FIFO emptied, buf_overflow cleared
  - if_* in the same cycle is discarded, even if if_valid=1
- Hold (no flush):
  - id_* registers keep their values.
  - If if_valid=1 and FIFO not full: push {if_pc,if_inst}, buf_count+1.
  - If if_valid=1 and FIFO full: drop the entry, set buf_overflow, count unchanged.
- Advance (no flush, no hold):
  - FIFO non-empty: id_* <= head entry, id_valid=1, pop.
    - If if_valid=1 in the same cycle, push the incoming entry at the tail.
    - Simultaneous push and pop is legal even when full; count is unchanged.
  - FIFO empty and if_valid=1: bypass. id_pc<=if_pc, id_inst<=if_inst, id_valid=1. Latency is 1 cycle.
  - FIFO empty and if_valid=0: bubble. id_pc=INIT_PC, id_inst=NOP_INST, id_valid=0.
- Ordering: strictly program order. A newly arriving instruction never bypasses a buffered one.
- FIFO storage:
  - Circular, with rd/wr pointers of $clog2(DEPTH) bits (min 1) and a separate count register.
  - Pointers wrap at DEPTH, not at the power of two.
- buf_count reflects occupancy after the edge. It never exceeds DEPTH.
- Outputs are all registered; there is no combinational path from inputs to id_*.

Test Plan:
- Reset release, if_valid=1 with pc 0x4, 0x8, 0xC on consecutive cycles, no stall -> id_pc 0x4, 0x8, 0xC one cycle later each, id_valid=1, buf_count stays 0.
- Hold for 2 cycles while pc 0x10 and 0x14 arrive, then release with if_valid=0 -> id frozen during hold, buf_count=2, then id_pc 0x10, then 0x14, then a bubble (id_valid=0, id_inst=NOP_INST).
- DEPTH=2, hold for 3 cycles with if_valid=1 (pc 0x20, 0x24, 0x28) -> buf_count=2, buf_overflow=1, 0x28 never reaches decode.
- FIFO full, release hold with if_valid=1 pc 0x30 -> pop 0x20 and push 0x30 in the same cycle, buf_count stays 2, order is 0x24 then 0x30.
- flush asserted together with hold and if_valid=1 while buf_count=2 -> next cycle id_valid=0, id_pc=INIT_PC, buf_count=0, buf_overflow=0.
- rst pulsed asynchronously between edges mid-hold with buf_count=1 -> outputs reset immediately without waiting for a clock edge, and the buffered entry is never issued.
